mpmc10_wdf_feeder: RTL and testbench

Write-data feeder between the mpmc10 byte-mask stage and the DDR controller user-interface write-data FIFO. It captures one full-width write word plus its byte-disable mask on a load strobe, splits them into UI-width beats, and drives the write-data channel with a valid/ready handshake. It marks the last beat of each burst and signals completion to the controller state machine.

---
 rtl/mpmc10_wdf_feeder.sv | 126 ++++++++++++
 tb/tb_mpmc10_wdf_feeder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mpmc10_wdf_feeder.sv
// mpmc10_wdf_feeder: captures one WID-bit write word and its byte-disable mask,
// then feeds it to the DDR UI write-data FIFO as WID/UIWID beats using valid/ready.
// Optional statistics counters are built in when MPMC10_WDF_STATS_EN is defined.
module mpmc10_wdf_feeder #(
   parameter int WID   = 256,
   parameter int UIWID = 128
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ld,
   input  logic [WID-1:0]       dat,
   input  logic [WID/8-1:0]     mask,
   output logic                 busy,
   output logic                 done,
   input  logic                 app_wdf_rdy,
   output logic                 app_wdf_wren,
   output logic                 app_wdf_end,
   output logic [UIWID-1:0]     app_wdf_data,
   output logic [UIWID/8-1:0]   app_wdf_mask
`ifdef MPMC10_WDF_STATS_EN
   ,
   output logic [31:0]          wbeat_cnt,
   output logic [31:0]          stall_cnt
`endif
);

   localparam int BEATS = WID / UIWID;
   localparam int MW    = UIWID / 8;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t            r_state;
   logic [BW-1:0]     r_beat;
   logic [WID-1:0]    r_hold_dat;
   logic [WID/8-1:0]  r_hold_mask;
   logic              r_busy, r_done, r_wren, r_end;
   logic [UIWID-1:0]  r_data;
   logic [MW-1:0]     r_mask;

   logic              w_accept;
   logic              w_last;
   logic [BW-1:0]     w_nxt;

   assign w_accept = r_wren & app_wdf_rdy;
   assign w_last   = (r_beat == LAST);
   assign w_nxt    = r_beat + BW'(1);

   // Burst FSM: every output is a register so app_wdf_rdy never reaches an output combinationally.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_beat      <= '0;
         r_hold_dat  <= '0;
         r_hold_mask <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_wren      <= 1'b0;
         r_end       <= 1'b0;
         r_data      <= '0;
         r_mask      <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (ld) begin
                  r_hold_dat  <= dat;
                  r_hold_mask <= mask;
                  r_beat      <= '0;
                  r_data      <= dat[UIWID-1:0];
                  r_mask      <= mask[MW-1:0];
                  r_end       <= (BEATS == 1);
                  r_wren      <= 1'b1;
                  r_busy      <= 1'b1;
                  r_state     <= SEND;
               end
            end
            SEND: begin
               // Without an accept, every app_wdf_* output simply holds.
               if (w_accept) begin
                  if (w_last) begin
                     r_wren  <= 1'b0;
                     r_end   <= 1'b0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= IDLE;
                  end else begin
                     r_beat <= w_nxt;
                     r_data <= r_hold_dat[w_nxt*UIWID +: UIWID];
                     r_mask <= r_hold_mask[w_nxt*MW +: MW];
                     r_end  <= (w_nxt == LAST);
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy         = r_busy;
   assign done         = r_done;
   assign app_wdf_wren = r_wren;
   assign app_wdf_end  = r_end;
   assign app_wdf_data = r_data;
   assign app_wdf_mask = r_mask;

`ifdef MPMC10_WDF_STATS_EN
   logic [31:0] r_wbeat_cnt, r_stall_cnt;

   // Accepted-beat and back-pressure counters; both wrap naturally at 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wbeat_cnt <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_accept)                r_wbeat_cnt <= r_wbeat_cnt + 32'd1;
         if (r_wren && !app_wdf_rdy)  r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign wbeat_cnt = r_wbeat_cnt;
   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_mpmc10_wdf_feeder.sv
// Directed testbench for mpmc10_wdf_feeder: a two-beat instance (256/128) and a
// single-beat instance (256/256), checked against hand-computed expectations.
module tb_mpmc10_wdf_feeder;

   localparam logic [127:0] PA = {32{4'hA}};
   localparam logic [127:0] PB = {32{4'hB}};
   localparam logic [127:0] P1 = {32{4'h1}};
   localparam logic [127:0] P2 = {32{4'h2}};
   localparam logic [127:0] P3 = {32{4'h3}};
   localparam logic [127:0] P4 = {32{4'h4}};

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         ld = 1'b0, rdy = 1'b1;
   logic [255:0] dat = '0;
   logic [31:0]  mask = '0;
   logic         busy, done, wren, wend;
   logic [127:0] wdata;
   logic [15:0]  wmask;

   logic         ld1 = 1'b0, rdy1 = 1'b1;
   logic [255:0] dat1 = '0;
   logic [31:0]  mask1 = '0;
   logic         busy1, done1, wren1, wend1;
   logic [255:0] wdata1;
   logic [31:0]  wmask1;

`ifdef MPMC10_WDF_STATS_EN
   logic [31:0]  wbeat, stall, wbeat1, stall1;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mpmc10_wdf_feeder #(.WID(256), .UIWID(128)) u_dut (
      .clk(clk), .rst(rst), .ld(ld), .dat(dat), .mask(mask),
      .busy(busy), .done(done), .app_wdf_rdy(rdy), .app_wdf_wren(wren),
      .app_wdf_end(wend), .app_wdf_data(wdata), .app_wdf_mask(wmask)
`ifdef MPMC10_WDF_STATS_EN
      , .wbeat_cnt(wbeat), .stall_cnt(stall)
`endif
   );

   mpmc10_wdf_feeder #(.WID(256), .UIWID(256)) u_dut1 (
      .clk(clk), .rst(rst), .ld(ld1), .dat(dat1), .mask(mask1),
      .busy(busy1), .done(done1), .app_wdf_rdy(rdy1), .app_wdf_wren(wren1),
      .app_wdf_end(wend1), .app_wdf_data(wdata1), .app_wdf_mask(wmask1)
`ifdef MPMC10_WDF_STATS_EN
      , .wbeat_cnt(wbeat1), .stall_cnt(stall1)
`endif
   );

   // Advance one clock and settle just after the edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick;
      tick;
      total++; if ({busy, done, wren, wend} !== 4'b0000) begin bad++; $display("FAIL reset_stat got=%b exp=0000", {busy, done, wren, wend}); end
      total++; if ({wdata, wmask} !== 144'd0) begin bad++; $display("FAIL reset_data got=%h/%h exp=0", wdata, wmask); end
      total++; if ({busy1, done1, wren1, wend1} !== 4'b0000) begin bad++; $display("FAIL reset_stat1 got=%b exp=0000", {busy1, done1, wren1, wend1}); end
      total++; if ({wdata1, wmask1} !== 288'd0) begin bad++; $display("FAIL reset_data1 got=%h/%h exp=0", wdata1, wmask1); end
`ifdef MPMC10_WDF_STATS_EN
      total++; if ({wbeat, stall} !== 64'd0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", wbeat, stall); end
`endif
      rst = 1'b0;
   endtask

   task automatic test_stall;
      rdy = 1'b0; dat = {PA, PB}; mask = 32'h0000_FFFF; ld = 1'b1;
      tick;
      ld = 1'b0;
      total++; if ({busy, done, wren, wend} !== 4'b1010) begin bad++; $display("FAIL stall_b0_stat got=%b exp=1010", {busy, done, wren, wend}); end
      total++; if (wdata !== PB || wmask !== 16'hFFFF) begin bad++; $display("FAIL stall_b0_data got=%h/%h exp=%h/ffff", wdata, wmask, PB); end
      for (int i = 0; i < 3; i++) begin
         tick;
         total++; if ({busy, done, wren, wend} !== 4'b1010) begin bad++; $display("FAIL stall_hold_stat[%0d] got=%b exp=1010", i, {busy, done, wren, wend}); end
         total++; if (wdata !== PB || wmask !== 16'hFFFF) begin bad++; $display("FAIL stall_hold_data[%0d] got=%h/%h exp=%h/ffff", i, wdata, wmask, PB); end
      end
      rdy = 1'b1;
      tick;
      total++; if ({busy, done, wren, wend} !== 4'b1011) begin bad++; $display("FAIL stall_b1_stat got=%b exp=1011", {busy, done, wren, wend}); end
      total++; if (wdata !== PA || wmask !== 16'h0000) begin bad++; $display("FAIL stall_b1_data got=%h/%h exp=%h/0000", wdata, wmask, PA); end
      tick;
      total++; if ({busy, done, wren, wend} !== 4'b0100) begin bad++; $display("FAIL stall_done got=%b exp=0100", {busy, done, wren, wend}); end
`ifdef MPMC10_WDF_STATS_EN
      total++; if (wbeat !== 32'd2 || stall !== 32'd3) begin bad++; $display("FAIL stall_cnt got=%0d/%0d exp=2/3", wbeat, stall); end
`endif
      tick;
      total++; if ({busy, done, wren, wend} !== 4'b0000) begin bad++; $display("FAIL stall_idle got=%b exp=0000", {busy, done, wren, wend}); end
   endtask

   task automatic test_basic;
      rdy = 1'b1; dat = {PA, PB}; mask = 32'h0000_FFFF; ld = 1'b1;
      tick;
      ld = 1'b0;
      total++; if ({busy, done, wren, wend} !== 4'b1010) begin bad++; $display("FAIL basic_b0_stat got=%b exp=1010", {busy, done, wren, wend}); end
      total++; if (wdata !== PB || wmask !== 16'hFFFF) begin bad++; $display("FAIL basic_b0_data got=%h/%h exp=%h/ffff", wdata, wmask, PB); end
      tick;
      total++; if ({busy, done, wren, wend} !== 4'b1011) begin bad++; $display("FAIL basic_b1_stat got=%b exp=1011", {busy, done, wren, wend}); end
      total++; if (wdata !== PA || wmask !== 16'h0000) begin bad++; $display("FAIL basic_b1_data got=%h/%h exp=%h/0000", wdata, wmask, PA); end
      tick;
      total++; if ({busy, done, wren, wend} !== 4'b0100) begin bad++; $display("FAIL basic_done got=%b exp=0100", {busy, done, wren, wend}); end
      tick;
      total++; if ({busy, done, wren, wend} !== 4'b0000) begin bad++; $display("FAIL basic_idle got=%b exp=0000", {busy, done, wren, wend}); end
   endtask

   // ld held for 6 edges: bursts start at edges 0 and 3 (second one in the done cycle).
   task automatic test_back_to_back;
      bit eb [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      bit ed [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      int ndone = 0;
      rdy = 1'b1; dat = {P3, P4}; mask = 32'h0F0F_F0F0; ld = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick;
         if (done) ndone++;
         total++; if (busy !== eb[i] || done !== ed[i]) begin bad++; $display("FAIL b2b_cycle[%0d] got=busy%b/done%b exp=busy%b/done%b", i, busy, done, eb[i], ed[i]); end
      end
      ld = 1'b0;
      tick;
      total++; if ({busy, done, wren} !== 3'b000) begin bad++; $display("FAIL b2b_idle got=%b exp=000", {busy, done, wren}); end
      total++; if (ndone !== 2) begin bad++; $display("FAIL b2b_bursts got=%0d exp=2", ndone); end
   endtask

   task automatic test_ld_ignored;
      rdy = 1'b0; dat = {P1, P2}; mask = 32'h1234_5678; ld = 1'b1;
      tick;
      total++; if ({busy, wren} !== 2'b11 || wdata !== P2 || wmask !== 16'h5678) begin bad++; $display("FAIL ign_b0 got=%b %h/%h exp=11 %h/5678", {busy, wren}, wdata, wmask, P2); end
      dat = {P3, P4}; mask = 32'hFFFF_FFFF;
      tick;
      total++; if (wdata !== P2 || wmask !== 16'h5678) begin bad++; $display("FAIL ign_stall got=%h/%h exp=%h/5678", wdata, wmask, P2); end
      ld = 1'b0; rdy = 1'b1;
      tick;
      total++; if ({busy, done, wren, wend} !== 4'b1011 || wdata !== P1 || wmask !== 16'h1234) begin bad++; $display("FAIL ign_b1 got=%b %h/%h exp=1011 %h/1234", {busy, done, wren, wend}, wdata, wmask, P1); end
      ld = 1'b1;
      tick;
      ld = 1'b0;
      total++; if ({busy, done, wren, wend} !== 4'b0100) begin bad++; $display("FAIL ign_done got=%b exp=0100", {busy, done, wren, wend}); end
      tick;
      total++; if ({busy, done, wren, wend} !== 4'b0000) begin bad++; $display("FAIL ign_idle got=%b exp=0000", {busy, done, wren, wend}); end
   endtask

   task automatic test_reset_mid;
      rdy = 1'b0; dat = {PA, PB}; mask = 32'h0000_FFFF; ld = 1'b1;
      tick;
      ld = 1'b0;
      tick;
      total++; if ({busy, done, wren, wend} !== 4'b1010) begin bad++; $display("FAIL rmid_stalled got=%b exp=1010", {busy, done, wren, wend}); end
      rst = 1'b1;
      tick;
      total++; if ({busy, done, wren, wend} !== 4'b0000 || wdata !== '0 || wmask !== '0) begin bad++; $display("FAIL rmid_reset got=%b %h/%h exp=0000 0/0", {busy, done, wren, wend}, wdata, wmask); end
`ifdef MPMC10_WDF_STATS_EN
      total++; if ({wbeat, stall} !== 64'd0) begin bad++; $display("FAIL rmid_cnt got=%0d/%0d exp=0/0", wbeat, stall); end
`endif
      rst = 1'b0; rdy = 1'b1;
      tick;
      total++; if ({busy, done, wren} !== 3'b000) begin bad++; $display("FAIL rmid_nodone got=%b exp=000", {busy, done, wren}); end
      dat = {P1, P2}; mask = 32'h1234_5678; ld = 1'b1;
      tick;
      ld = 1'b0;
      total++; if ({busy, wren, wend} !== 3'b110 || wdata !== P2 || wmask !== 16'h5678) begin bad++; $display("FAIL rmid_b0 got=%b %h/%h exp=110 %h/5678", {busy, wren, wend}, wdata, wmask, P2); end
      tick;
      total++; if ({busy, wren, wend} !== 3'b111 || wdata !== P1 || wmask !== 16'h1234) begin bad++; $display("FAIL rmid_b1 got=%b %h/%h exp=111 %h/1234", {busy, wren, wend}, wdata, wmask, P1); end
      tick;
      total++; if ({busy, done, wren, wend} !== 4'b0100) begin bad++; $display("FAIL rmid_done got=%b exp=0100", {busy, done, wren, wend}); end
   endtask

   task automatic test_single_beat;
      rdy1 = 1'b1; dat1 = {PA, PB}; mask1 = 32'h0000_FFFF; ld1 = 1'b1;
      tick;
      ld1 = 1'b0;
      total++; if ({busy1, done1, wren1, wend1} !== 4'b1011) begin bad++; $display("FAIL one_beat_stat got=%b exp=1011", {busy1, done1, wren1, wend1}); end
      total++; if (wdata1 !== {PA, PB} || wmask1 !== 32'h0000_FFFF) begin bad++; $display("FAIL one_beat_data got=%h/%h exp=%h/0000ffff", wdata1, wmask1, {PA, PB}); end
      tick;
      total++; if ({busy1, done1, wren1, wend1} !== 4'b0100) begin bad++; $display("FAIL one_beat_done got=%b exp=0100", {busy1, done1, wren1, wend1}); end
      tick;
      total++; if ({busy1, done1, wren1, wend1} !== 4'b0000) begin bad++; $display("FAIL one_beat_idle got=%b exp=0000", {busy1, done1, wren1, wend1}); end
   endtask

   initial begin
      test_reset;
      test_stall;
      test_basic;
      test_back_to_back;
      test_ld_ignored;
      test_reset_mid;
      test_single_beat;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
